// File: rtl/cycle_sequencer.sv
// Instruction cycle sequencer (FETCH/EXEC0/EXEC1/IRQ/HALT); interrupt support under `SEQ_IRQ_EN.
// Latency: 2 clocks per single-cycle op; backpressure: mem_ready low stalls FETCH and EXEC1 memory ops.
module cycle_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  mem_data,
  input  logic        mem_ready,
  input  logic        irq,
  input  logic        cli,
  input  logic        halt_req,
  output logic [7:0]  inst,
  output logic        cycle,
  output logic        mem_req,
  output logic        pc_inc,
  output logic        exec_en,
  output logic        int_ack,
  output logic        int_en,
  output logic        halted,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EXEC0 = 3'd1,
    S_EXEC1 = 3'd2,
    S_IRQ   = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t state;
  state_t boundary_next;
  logic   mem_op;
  logic   exec1_done;
  logic   complete;
  logic   take_irq;

  assign mem_op     = inst[7] & ~inst[6];
  assign exec1_done = (state == S_EXEC1) && (!mem_op || mem_ready);
  assign complete   = ((state == S_EXEC0) && !inst[7]) || exec1_done;

`ifdef SEQ_IRQ_EN
  assign take_irq = irq & int_en;

  // int_en is read before this clock's cli update, so a new enable counts from the next boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_en <= 1'b0;
    end else if (state == S_IRQ) begin
      int_en <= 1'b0;
    end else if ((state == S_EXEC0) && cli) begin
      int_en <= 1'b1;
    end
  end
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = irq ^ cli;
  assign take_irq          = 1'b0;
  assign int_en            = 1'b0;
`endif

  always_comb begin
    boundary_next = S_FETCH;
    if (take_irq) begin
      boundary_next = S_IRQ;
    end else if (halt_req) begin
      boundary_next = S_HALT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      inst    <= 8'h00;
      retired <= 16'h0000;
    end else begin
      case (state)
        S_FETCH: begin
          if (mem_ready) begin
            inst  <= mem_data;
            state <= S_EXEC0;
          end
        end
        S_EXEC0: state <= inst[7] ? S_EXEC1 : boundary_next;
        S_EXEC1: begin
          if (exec1_done) begin
            state <= boundary_next;
          end
        end
        S_IRQ:   state <= S_FETCH;
        S_HALT: begin
          if (take_irq) begin
            state <= S_IRQ;
          end else if (!halt_req) begin
            state <= S_FETCH;
          end
        end
        default: state <= S_FETCH;
      endcase
      if (complete) begin
        retired <= retired + 16'd1;
      end
    end
  end

  // Moore decode; pc_inc is gated by rst_n so it stays low while reset holds the block in FETCH.
  assign cycle   = (state == S_EXEC1);
  assign mem_req = (state == S_FETCH) || ((state == S_EXEC1) && mem_op);
  assign pc_inc  = (state == S_FETCH) && mem_ready && rst_n;
  assign exec_en = (state == S_EXEC0) || exec1_done;
  assign int_ack = (state == S_IRQ);
  assign halted  = (state == S_HALT);

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed self-checking bench for cycle_sequencer; interrupt cases run when SEQ_IRQ_EN is defined.
module tb_cycle_sequencer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  mem_data;
  logic        mem_ready;
  logic        irq;
  logic        cli;
  logic        halt_req;
  logic [7:0]  inst;
  logic        cycle;
  logic        mem_req;
  logic        pc_inc;
  logic        exec_en;
  logic        int_ack;
  logic        int_en;
  logic        halted;
  logic [15:0] retired;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_ret = 0;

  cycle_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .irq       (irq),
    .cli       (cli),
    .halt_req  (halt_req),
    .inst      (inst),
    .cycle     (cycle),
    .mem_req   (mem_req),
    .pc_inc    (pc_inc),
    .exec_en   (exec_en),
    .int_ack   (int_ack),
    .int_en    (int_en),
    .halted    (halted),
    .retired   (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From FETCH: present one byte for one clock; returns one step into EXEC0.
  task automatic do_fetch(input logic [7:0] d);
    mem_data  = d;
    mem_ready = 1'b1;
    #1;
    check("fetch_pc_inc", {31'd0, pc_inc}, 32'd1);
    tick();
    mem_ready = 1'b0;
    check("fetch_inst", {24'd0, inst}, {24'd0, d});
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_data  = 8'hAA;
    mem_ready = 1'b1;
    irq       = 1'b0;
    cli       = 1'b0;
    halt_req  = 1'b0;
    #2;
    check("rst_inst",    {24'd0, inst}, 32'h00);
    check("rst_retired", {16'd0, retired}, 32'h0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd1);
    check("rst_pc_inc",  {31'd0, pc_inc}, 32'd0);
    check("rst_exec_en", {31'd0, exec_en}, 32'd0);
    check("rst_cycle",   {31'd0, cycle}, 32'd0);
    check("rst_halted",  {31'd0, halted}, 32'd0);
    check("rst_int_ack", {31'd0, int_ack}, 32'd0);
    check("rst_int_en",  {31'd0, int_en}, 32'd0);
    tick();
    check("rst_hold_inst", {24'd0, inst}, 32'h00);
    rst_n     = 1'b1;
    mem_ready = 1'b0;

    // Single-cycle instruction
    do_fetch(8'h05);
    check("t1_cycle",   {31'd0, cycle}, 32'd0);
    check("t1_exec_en", {31'd0, exec_en}, 32'd1);
    check("t1_mem_req", {31'd0, mem_req}, 32'd0);
    tick();
    exp_ret++;
    check("t1_retired", {16'd0, retired}, exp_ret);
    check("t1_fetch",   {31'd0, mem_req}, 32'd1);
    check("t1_exec_off", {31'd0, exec_en}, 32'd0);
    check("t1_pc_off",  {31'd0, pc_inc}, 32'd0);

    // Memory op with a 3-clock stall in EXEC1
    do_fetch(8'h80);
    check("t2_exec0_en", {31'd0, exec_en}, 32'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("t2_stall_cycle",   {31'd0, cycle}, 32'd1);
      check("t2_stall_exec_en", {31'd0, exec_en}, 32'd0);
      check("t2_stall_mem_req", {31'd0, mem_req}, 32'd1);
      check("t2_stall_retired", {16'd0, retired}, exp_ret);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check("t2_final_cycle",   {31'd0, cycle}, 32'd1);
    check("t2_final_exec_en", {31'd0, exec_en}, 32'd1);
    tick();
    mem_ready = 1'b0;
    exp_ret++;
    check("t2_retired", {16'd0, retired}, exp_ret);
    check("t2_cycle",   {31'd0, cycle}, 32'd0);

    // Two-cycle non-memory op
    do_fetch(8'hC0);
    tick();
    check("t3_cycle",   {31'd0, cycle}, 32'd1);
    check("t3_mem_req", {31'd0, mem_req}, 32'd0);
    check("t3_exec_en", {31'd0, exec_en}, 32'd1);
    tick();
    exp_ret++;
    check("t3_retired", {16'd0, retired}, exp_ret);
    check("t3_fetch",   {31'd0, mem_req}, 32'd1);

    // halt_req pulse that drops before the boundary has no effect
    do_fetch(8'h81);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    exp_ret++;
    check("t4_halted",  {31'd0, halted}, 32'd0);
    check("t4_mem_req", {31'd0, mem_req}, 32'd1);
    check("t4_retired", {16'd0, retired}, exp_ret);

    // Halt at boundary, hold, release
    do_fetch(8'h02);
    halt_req = 1'b1;
    tick();
    exp_ret++;
    check("t5_halted",  {31'd0, halted}, 32'd1);
    check("t5_mem_req", {31'd0, mem_req}, 32'd0);
    check("t5_retired", {16'd0, retired}, exp_ret);
    tick();
    check("t5_hold", {31'd0, halted}, 32'd1);
    halt_req = 1'b0;
    #1;
    check("t5_still", {31'd0, halted}, 32'd1);
    tick();
    check("t5_resume_halted",  {31'd0, halted}, 32'd0);
    check("t5_resume_mem_req", {31'd0, mem_req}, 32'd1);

`ifdef SEQ_IRQ_EN
    // cli enables interrupts, but not for the boundary of the same instruction
    do_fetch(8'h03);
    irq = 1'b1;
    cli = 1'b1;
    tick();
    cli = 1'b0;
    exp_ret++;
    check("t6_int_en",  {31'd0, int_en}, 32'd1);
    check("t6_int_ack", {31'd0, int_ack}, 32'd0);
    check("t6_fetch",   {31'd0, mem_req}, 32'd1);
    check("t6_retired", {16'd0, retired}, exp_ret);
    // irq and halt_req together: IRQ wins, HALT at the following boundary
    do_fetch(8'h04);
    halt_req = 1'b1;
    tick();
    exp_ret++;
    check("t7_int_ack", {31'd0, int_ack}, 32'd1);
    check("t7_halted",  {31'd0, halted}, 32'd0);
    check("t7_mem_req", {31'd0, mem_req}, 32'd0);
    check("t7_retired", {16'd0, retired}, exp_ret);
    tick();
    check("t7_ack_off", {31'd0, int_ack}, 32'd0);
    check("t7_int_en",  {31'd0, int_en}, 32'd0);
    check("t7_fetch",   {31'd0, mem_req}, 32'd1);
    do_fetch(8'h05);
    tick();
    exp_ret++;
    check("t7_halt_next", {31'd0, halted}, 32'd1);
    check("t7_retired2",  {16'd0, retired}, exp_ret);
    halt_req = 1'b0;
    irq      = 1'b0;
    tick();
    check("t7_resume", {31'd0, halted}, 32'd0);
`else
    // Interrupt inputs are ignored when the feature is compiled out
    do_fetch(8'h03);
    irq = 1'b1;
    cli = 1'b1;
    tick();
    cli = 1'b0;
    exp_ret++;
    check("t6_int_en",  {31'd0, int_en}, 32'd0);
    check("t6_int_ack", {31'd0, int_ack}, 32'd0);
    check("t6_fetch",   {31'd0, mem_req}, 32'd1);
    check("t6_retired", {16'd0, retired}, exp_ret);
    irq = 1'b0;
`endif

    // Counter wrap
    force dut.retired = 16'hFFFF;
    #1;
    release dut.retired;
    #1;
    check("t8_preload", {16'd0, retired}, 32'hFFFF);
    do_fetch(8'h06);
    tick();
    check("t8_wrap", {16'd0, retired}, 32'h0000);

    // Asynchronous reset in the middle of an EXEC1 stall
    do_fetch(8'h80);
    tick();
    tick();
    check("t9_stalled", {31'd0, cycle}, 32'd1);
    #3;
    mem_ready = 1'b1;
    rst_n     = 1'b0;
    #1;
    check("t9_cycle",   {31'd0, cycle}, 32'd0);
    check("t9_exec_en", {31'd0, exec_en}, 32'd0);
    check("t9_mem_req", {31'd0, mem_req}, 32'd1);
    check("t9_pc_inc",  {31'd0, pc_inc}, 32'd0);
    check("t9_inst",    {24'd0, inst}, 32'h00);
    check("t9_retired", {16'd0, retired}, 32'h0);
    check("t9_halted",  {31'd0, halted}, 32'd0);
    mem_data = 8'h07;
    #1;
    rst_n = 1'b1;
    #1;
    check("t9_rel_pc_inc", {31'd0, pc_inc}, 32'd1);
    tick();
    mem_ready = 1'b0;
    check("t9_rel_inst",    {24'd0, inst}, 32'h07);
    check("t9_rel_exec_en", {31'd0, exec_en}, 32'd1);
    check("t9_rel_cycle",   {31'd0, cycle}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cycle_sequencer.md
CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

Interface
REQ-001 SHALL have one clock and one reset: the reset is asynchronous and active-low.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 mem_data  input  8  instruction/data bus from memory.
REQ-005 mem_ready  input  1  memory completes the current access this cycle.
REQ-006 irq  input  1  level interrupt request.
REQ-007 cli  input  1  decoder CLI strobe, sampled only in EXEC0; re-enables interrupts.
REQ-008 halt_req  input  1  level request to halt at the next instruction boundary.
REQ-009 inst  output  8  instruction register, driven to the decoder.
REQ-010 cycle  output  1  decoder cycle bit: 0 in EXEC0, 1 in EXEC1.
REQ-011 mem_req  output  1  memory access requested (FETCH, or EXEC1 with a memory op).
REQ-012 pc_inc  output  1  one-clock pulse when a fetch completes.
REQ-013 exec_en  output  1  datapath write enable: high in EXEC0, and in EXEC1 on its final clock.
REQ-014 int_ack  output  1  one-clock interrupt acknowledge pulse.
REQ-015 int_en  output  1  interrupt enable flag.
REQ-016 halted  output  1  high while in HALT.
REQ-017 retired  output  16  count of completed instructions.

Function
REQ-018 States SHALL be FETCH, EXEC0, EXEC1, IRQ and HALT, held in a registered state machine.
REQ-019 FETCH: mem_req=1; on mem_ready, inst<=mem_data, pc_inc pulses, and the next state is EXEC0; otherwise the block stays in FETCH.
REQ-020 EXEC0: cycle=0 and exec_en=1 for exactly one clock.
  - inst[7]=1 -> EXEC1.
  - Otherwise the boundary rules (REQ-023) apply.
REQ-021 EXEC1 (cycle=1) advances as follows.
  - Memory op (inst[7]=1, inst[6]=0): mem_req=1; stall until mem_ready; exec_en high only on the mem_ready clock.
  - Any other op: one clock with exec_en=1.
  - Then apply the boundary rules.
REQ-022 An instruction is complete when it leaves EXEC0 (single-cycle) or EXEC1 (two-cycle).
  - retired increments by 1 on completion.
  - retired wraps from 0xFFFF to 0x0000.
REQ-023 Boundary rules, applied at completion in priority order.
  - irq&int_en -> IRQ.
  - Else halt_req -> HALT.
  - Else -> FETCH.
REQ-024 IRQ lasts one clock: int_ack=1, int_en<=0, then -> FETCH.
REQ-025 HALT: halted=1, mem_req=0; the block stays while halt_req=1 and returns to FETCH on the clock after halt_req=0.
  - With SEQ_IRQ_EN defined, irq&int_en in HALT -> IRQ.
REQ-026 cli=1 in EXEC0 sets int_en<=1; cli is ignored in every other state.
  - If the same instruction completes with irq pending, the new int_en value counts from the next boundary only.
REQ-027 halt_req and irq are sampled only at instruction boundaries (and in HALT); changes mid-instruction have no effect.
REQ-028 The EXEC1 stall has no timeout; mem_ready low holds all outputs stable.
REQ-029 Outputs cycle, mem_req, exec_en, int_ack, halted and pc_inc are decoded from state (Moore), except pc_inc and the EXEC1 exec_en, which are qualified by mem_ready.

Reset
REQ-030 rst_n=0 SHALL immediately force the following values, regardless of the current state including mid-stall:
  - state=FETCH, inst=0x00, int_en=0, retired=0.
  - int_ack=0, pc_inc=0, exec_en=0, cycle=0, halted=0.
REQ-031 After reset release, the first rising edge evaluates FETCH normally; mem_req is 1 during reset.

Configuration
REQ-032 Macro SEQ_IRQ_EN controls interrupt support.
  - Defined: REQ-006/007/014/015/024/026 are implemented as above.
  - Undefined: the IRQ state is absent; irq and cli are ignored; int_ack and int_en are tied 0; the boundary rules reduce to halt_req -> HALT, else FETCH.

Verification
REQ-033 Single-cycle instruction: reset, mem_data=0x05, mem_ready=1.
  - Required: FETCH->EXEC0->FETCH.
  - Required: inst=0x05, cycle stays 0, pc_inc one pulse, retired=1.
REQ-034 Two-cycle memory op with stall: mem_data=0x80, mem_ready low for 3 clocks in EXEC1.
  - Required: cycle=1 for 4 clocks.
  - Required: exec_en high only on the final clock; retired increments once.
REQ-035 Interrupt (SEQ_IRQ_EN defined): execute an instruction with cli=1, then hold irq=1.
  - Required: int_en=1 after EXEC0.
  - Required: at the next boundary, an int_ack pulse, int_en=0, then FETCH.
REQ-036 Simultaneous irq and halt_req at a boundary with int_en=1.
  - Required: IRQ first, then FETCH; HALT is entered only at the following boundary if halt_req is still 1.
REQ-037 Counter wrap: preload to 0xFFFF by 65535 retirements (or force), complete one more instruction.
  - Required: retired=0x0000.
REQ-038 Reset mid-stall: assert rst_n=0 during an EXEC1 stall.
  - Required: all REQ-030 values immediately, without waiting for clk.
  - Required: a normal fetch after release.
